// File: rtl/code_lock_pkg.sv
// Shared types and sizing helpers for the keypad unlock sequencer.
package code_lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        UNLOCK,
        LOCKOUT
    } lock_state_t;

    // Width of a down-counter able to hold the largest of the three load values.
    function automatic int timer_width(input int unlock_cyc, input int lock_cyc, input int entry_to);
        int m;
        m = unlock_cyc;
        if (lock_cyc > m) m = lock_cyc;
        if (entry_to > m) m = entry_to;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter: load wins over count, decrements while en is high.
module lock_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] value_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_reg <= '0;
        end else if (load) begin
            value_reg <= load_val;
        end else if (en) begin
            value_reg <= value_reg - 1'b1;
        end
    end

    assign value = value_reg;
    assign zero  = (value_reg == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Frames keypad bits into fixed-length attempts for the "110" detector and
// sequences unlock, failure counting and timed lockout.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int FRAME_LEN  = 3,
    parameter int MAX_FAIL   = 3,
    parameter int UNLOCK_CYC = 16,
    parameter int LOCK_CYC   = 64,
    parameter int ENTRY_TO   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_valid,
    input  logic                          bit_in,
    input  logic                          lock_req,
    input  logic                          pat_hit,
    output logic                          det_bit,
    output logic                          det_en,
    output logic                          det_clr,
    output logic                          unlock,
    output logic                          lockout,
    output logic                          alarm,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int TW = timer_width(UNLOCK_CYC, LOCK_CYC, ENTRY_TO);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int CW = $clog2(FRAME_LEN + 1);

    lock_state_t   state_reg;
    logic [CW-1:0] bit_cnt_reg;
    logic [FW-1:0] fail_cnt_reg;
    logic          det_bit_reg, det_en_reg, det_clr_reg;
    logic          unlock_reg, lockout_reg, alarm_reg;

    // Timer 0 times UNLOCK/LOCKOUT, timer 1 is the inter-bit gap timer.
    logic [1:0]    tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0] tmr_load_val [2];
    logic [TW-1:0] tmr_value    [2];

    logic bit_accept, frame_full, hold_last, gap_last;

    assign frame_full = (bit_cnt_reg == CW'(FRAME_LEN));
    assign bit_accept = bit_valid && ((state_reg == IDLE) || (state_reg == ENTRY && !frame_full));

    assign tmr_load[0]     = (state_reg == CHECK) && (pat_hit || fail_cnt_reg == FW'(MAX_FAIL - 1));
    assign tmr_load_val[0] = pat_hit ? TW'(UNLOCK_CYC) : TW'(LOCK_CYC);
    assign tmr_load[1]     = bit_accept;
    assign tmr_load_val[1] = TW'(ENTRY_TO);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_timer
            // Counters run down to zero and rest there until the next load.
            assign tmr_en[gi] = !tmr_zero[gi];
            lock_timer #(.W(TW)) u_timer (
                .clk      (clk),
                .rst      (rst),
                .load     (tmr_load[gi]),
                .en       (tmr_en[gi]),
                .load_val (tmr_load_val[gi]),
                .value    (tmr_value[gi]),
                .zero     (tmr_zero[gi])
            );
        end
    endgenerate

    // Leaving on the edge where the count is 1 makes a load of N last N cycles.
    assign hold_last = (tmr_value[0] == TW'(1));
    assign gap_last  = (tmr_value[1] == TW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            fail_cnt_reg <= '0;
            det_bit_reg  <= 1'b0;
            det_en_reg   <= 1'b0;
            det_clr_reg  <= 1'b1;
            unlock_reg   <= 1'b0;
            lockout_reg  <= 1'b0;
            alarm_reg    <= 1'b0;
        end else begin
            det_en_reg <= 1'b0;
            alarm_reg  <= 1'b0;
            if (bit_accept) begin
                det_en_reg  <= 1'b1;
                det_bit_reg <= bit_in;
            end
            case (state_reg)
                IDLE: begin
                    if (bit_valid) begin
                        bit_cnt_reg <= CW'(1);
                        det_clr_reg <= 1'b0;
                        state_reg   <= ENTRY;
                    end
                end
                ENTRY: begin
                    // A full frame waits one cycle so the detector result lines up with CHECK.
                    if (frame_full) begin
                        state_reg <= CHECK;
                    end else if (bit_valid) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end else if (gap_last) begin
                        bit_cnt_reg <= '0;
                        det_clr_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                CHECK: begin
                    bit_cnt_reg <= '0;
                    det_clr_reg <= 1'b1;
                    if (pat_hit) begin
                        fail_cnt_reg <= '0;
                        unlock_reg   <= 1'b1;
                        state_reg    <= UNLOCK;
                    end else if (fail_cnt_reg == FW'(MAX_FAIL - 1)) begin
                        fail_cnt_reg <= FW'(MAX_FAIL);
                        lockout_reg  <= 1'b1;
                        alarm_reg    <= 1'b1;
                        state_reg    <= LOCKOUT;
                    end else begin
                        fail_cnt_reg <= fail_cnt_reg + 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                UNLOCK: begin
                    if (lock_req || hold_last) begin
                        unlock_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                LOCKOUT: begin
                    if (hold_last) begin
                        lockout_reg  <= 1'b0;
                        fail_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign det_bit  = det_bit_reg;
    assign det_en   = det_en_reg;
    assign det_clr  = det_clr_reg;
    assign unlock   = unlock_reg;
    assign lockout  = lockout_reg;
    assign alarm    = alarm_reg;
    assign fail_cnt = fail_cnt_reg;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Closed-loop bench: "110" detector model feeds pat_hit, an attempt-level model
// predicts every output each cycle, and directed scenarios add literal checks.
module tb_code_lock_ctrl;

    localparam int FRAME_LEN  = 3;
    localparam int MAX_FAIL   = 3;
    localparam int UNLOCK_CYC = 16;
    localparam int LOCK_CYC   = 64;
    localparam int ENTRY_TO   = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid, bit_in, lock_req, pat_hit;
    logic       det_bit, det_en, det_clr, unlock, lockout, alarm;
    logic [1:0] fail_cnt;

    int errors = 0;
    int checks = 0;

    code_lock_ctrl #(
        .FRAME_LEN(FRAME_LEN), .MAX_FAIL(MAX_FAIL), .UNLOCK_CYC(UNLOCK_CYC),
        .LOCK_CYC(LOCK_CYC), .ENTRY_TO(ENTRY_TO)
    ) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .lock_req(lock_req), .pat_hit(pat_hit), .det_bit(det_bit),
        .det_en(det_en), .det_clr(det_clr), .unlock(unlock),
        .lockout(lockout), .alarm(alarm), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // "110" detector: pat_hit one cycle after the third det_en of 1,1,0.
    logic [2:0] det_hist;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_hist <= '0;
            pat_hit  <= 1'b0;
        end else if (det_clr) begin
            det_hist <= '0;
            pat_hit  <= 1'b0;
        end else if (det_en) begin
            det_hist <= {det_hist[1:0], det_bit};
            pat_hit  <= ({det_hist[1:0], det_bit} == 3'b110);
        end else begin
            pat_hit <= 1'b0;
        end
    end

    // Attempt-level model: cycles left in unlock/lockout, bits gathered, idle gap.
    int   m_nbits, m_gap, m_unl, m_lck, m_fail;
    bit   m_check;
    logic e_det_en, e_det_bit, e_det_clr, e_unlock, e_lockout, e_alarm;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_nbits = 0; m_gap = 0; m_unl = 0; m_lck = 0; m_fail = 0; m_check = 0;
            e_det_en = 0; e_det_bit = 0; e_det_clr = 1; e_unlock = 0; e_lockout = 0; e_alarm = 0;
        end else begin
            e_det_en = 0;
            e_alarm  = 0;
            if (m_lck > 0) begin
                m_lck--;
                if (m_lck == 0) m_fail = 0;
            end else if (m_unl > 0) begin
                if (lock_req) m_unl = 0;
                else m_unl--;
            end else if (m_check) begin
                m_check = 0;
                m_nbits = 0;
                if (pat_hit) begin
                    m_fail = 0;
                    m_unl  = UNLOCK_CYC;
                end else if (m_fail + 1 == MAX_FAIL) begin
                    m_fail  = MAX_FAIL;
                    m_lck   = LOCK_CYC;
                    e_alarm = 1;
                end else begin
                    m_fail++;
                end
            end else if (m_nbits == FRAME_LEN) begin
                m_check = 1;
            end else if (bit_valid) begin
                m_nbits++;
                m_gap     = ENTRY_TO;
                e_det_en  = 1;
                e_det_bit = bit_in;
            end else if (m_nbits > 0) begin
                m_gap--;
                if (m_gap == 0) m_nbits = 0;
            end
            e_unlock  = (m_unl > 0);
            e_lockout = (m_lck > 0);
            e_det_clr = (m_nbits == 0);
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("det_en", int'(det_en), int'(e_det_en));
            if (e_det_en) chk("det_bit", int'(det_bit), int'(e_det_bit));
            chk("det_clr", int'(det_clr), int'(e_det_clr));
            chk("unlock", int'(unlock), int'(e_unlock));
            chk("lockout", int'(lockout), int'(e_lockout));
            chk("alarm", int'(alarm), int'(e_alarm));
            chk("fail_cnt", int'(fail_cnt), m_fail);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic [7:0] bits);
        for (int i = n - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_in    = bits[i];
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Leaves the bench just after the edge that follows CHECK.
    task automatic attempt(input logic [2:0] bits);
        send_n(3, {5'b0, bits});
        tick();
        tick();
        $display("attempt bits=%b fail_cnt=%0d unlock=%0b lockout=%0b alarm=%0b",
                 bits, fail_cnt, unlock, lockout, alarm);
    endtask

    int n, a, d;

    initial begin
        rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; lock_req = 1'b0;
        repeat (3) tick();
        chk("rst_det_clr", int'(det_clr), 1);
        chk("rst_det_en", int'(det_en), 0);
        chk("rst_unlock", int'(unlock), 0);
        chk("rst_lockout", int'(lockout), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);

        // Correct code right after reset release; unlock for exactly 16 cycles.
        rst = 1'b1;
        send_n(3, 8'b110);
        tick();
        chk("t1_unlock_edge3", int'(unlock), 0);
        tick();
        chk("t1_unlock_edge4", int'(unlock), 1);
        chk("t1_fail_cnt", int'(fail_cnt), 0);
        n = 0;
        repeat (40) begin
            if (unlock) n++;
            tick();
        end
        chk("t1_unlock_len", n, 16);
        chk("t1_det_clr_after", int'(det_clr), 1);
        $display("unlock held %0d cycles", n);

        // Three wrong codes: fail_cnt 1, 2, then lockout with alarm.
        attempt(3'b101);
        chk("t2_fail1", int'(fail_cnt), 1);
        attempt(3'b101);
        chk("t2_fail2", int'(fail_cnt), 2);
        chk("t2_no_lockout", int'(lockout), 0);
        attempt(3'b101);
        chk("t2_lockout", int'(lockout), 1);
        chk("t2_fail3", int'(fail_cnt), 3);
        n = 0; a = 0; d = 0;
        repeat (64) begin
            if (lockout) n++;
            if (alarm) a++;
            if (det_en) d++;
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        chk("t2_lockout_len", n, 64);
        chk("t2_alarm_pulses", a, 1);
        chk("t2_bits_ignored", d, 0);
        chk("t2_lockout_end", int'(lockout), 0);
        chk("t2_fail_cleared", int'(fail_cnt), 0);
        $display("lockout held %0d cycles alarm pulses %0d", n, a);

        // Two bits then silence: abort to IDLE after 32 idle cycles, no failure.
        send_n(2, 8'b11);
        repeat (31) tick();
        chk("t3_det_clr_before", int'(det_clr), 0);
        tick();
        chk("t3_det_clr_abort", int'(det_clr), 1);
        chk("t3_fail_cnt", int'(fail_cnt), 0);
        attempt(3'b110);
        chk("t3_unlock", int'(unlock), 1);
        repeat (16) tick();
        chk("t3_unlock_end", int'(unlock), 0);

        // Early relock at unlock cycle 5; bits during unlock are not forwarded.
        attempt(3'b110);
        chk("t4_unlock", int'(unlock), 1);
        d = 0;
        bit_valid = 1'b1;
        repeat (4) begin
            tick();
            if (det_en) d++;
        end
        lock_req = 1'b1;
        tick();
        if (det_en) d++;
        lock_req  = 1'b0;
        bit_valid = 1'b0;
        chk("t4_unlock_drop", int'(unlock), 0);
        chk("t4_no_det_en", d, 0);
        chk("t4_det_clr", int'(det_clr), 1);

        // Two failures then success clears the count; lock_req lands on expiry edge.
        attempt(3'b101);
        chk("t5_fail1", int'(fail_cnt), 1);
        attempt(3'b101);
        chk("t5_fail2", int'(fail_cnt), 2);
        attempt(3'b110);
        chk("t5_unlock", int'(unlock), 1);
        chk("t5_fail_reset", int'(fail_cnt), 0);
        repeat (15) tick();
        chk("t5_unlock_last", int'(unlock), 1);
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        chk("t5_unlock_end", int'(unlock), 0);
        attempt(3'b101);
        chk("t5_single_fail", int'(fail_cnt), 1);
        chk("t5_no_lockout", int'(lockout), 0);

        // Asynchronous reset mid-lockout, mid-entry and mid-unlock.
        attempt(3'b101);
        attempt(3'b101);
        repeat (10) tick();
        chk("t6_in_lockout", int'(lockout), 1);
        rst = 1'b0;
        #1;
        chk("t6_lockout_async", int'(lockout), 0);
        chk("t6_fail_async", int'(fail_cnt), 0);
        chk("t6_det_clr_async", int'(det_clr), 1);
        tick();
        rst = 1'b1;
        send_n(2, 8'b11);
        chk("t6_entry_det_en", int'(det_en), 1);
        rst = 1'b0;
        #1;
        chk("t6_entry_det_en_rst", int'(det_en), 0);
        chk("t6_entry_det_clr_rst", int'(det_clr), 1);
        tick();
        rst = 1'b1;
        attempt(3'b110);
        chk("t6_unlock", int'(unlock), 1);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("t6_unlock_async", int'(unlock), 0);
        tick();
        rst = 1'b1;
        attempt(3'b110);
        chk("t6_unlock_again", int'(unlock), 1);
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
